memoria_responder: RTL and testbench



---
 rtl/memoria_responder.sv | 109 ++++++++++
 tb/tb_memoria_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_responder.sv
`default_nettype none
// ============================================================================
// memoria_responder : RAM-side responder for the cache/RAM request interface,
// single outstanding request, configurable access latency.      Rev 1.0
// ============================================================================
module memoria_responder #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] data_out
);

  localparam int         DEPTH  = 2**ADDR_W;
  localparam logic [3:0] C_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                accept;
  logic                access;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = C_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign ack      = ack_q;
  assign data_out = rdata_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= access;
      // Only the values captured at acceptance drive the access.
      if (accept) begin
        addr_q  <= address;
        we_q    <= read_write;
        wdata_q <= data_in;
      end
      if (access && !we_q) begin
        rdata_q <= mem_q[addr_q];
      end
    end
  end

  // Reset wipes the whole array, so an aborted write can never land later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (access && we_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memoria_responder.sv
`default_nettype none
// tb_memoria_responder : directed tests on LATENCY=3 and LATENCY=1 instances,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_memoria_responder;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_s  [2];
  logic       rw_s   [2];
  logic [4:0] addr_s [2];
  logic [7:0] din_s  [2];
  logic       rdy_s  [2];
  logic       ack_s  [2];
  logic [7:0] dout_s [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  memoria_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(LAT0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req_s[0]), .read_write(rw_s[0]),
    .address(addr_s[0]), .data_in(din_s[0]), .ready(rdy_s[0]), .ack(ack_s[0]),
    .data_out(dout_s[0])
  );

  memoria_responder #(.ADDR_W(5), .DATA_W(8), .LATENCY(LAT1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req_s[1]), .read_write(rw_s[1]),
    .address(addr_s[1]), .data_in(din_s[1]), .ready(rdy_s[1]), .ack(ack_s[1]),
    .data_out(dout_s[1])
  );

  always #5 clock = ~clock;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request is busy for edges acc+1 .. acc+LAT+1,
  // the memory is touched and ack raised on edge acc+LAT.
  logic [7:0] m_mem  [2][32];
  logic       m_pend [2];
  int         m_acc  [2];
  logic       m_we   [2];
  logic [4:0] m_addr [2];
  logic [7:0] m_wd   [2];
  logic       m_ack  [2];
  logic [7:0] m_dout [2];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] <= 1'b0;
        m_ack[i]  <= 1'b0;
        m_dout[i] <= 8'h00;
        for (int a = 0; a < 32; a++) m_mem[i][a] <= 8'h00;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        m_ack[i] <= 1'b0;
        if (m_pend[i]) begin
          if (cyc == m_acc[i] + lat_of(i)) begin
            m_ack[i] <= 1'b1;
            if (m_we[i]) m_mem[i][m_addr[i]] <= m_wd[i];
            else         m_dout[i] <= m_mem[i][m_addr[i]];
          end else if (cyc == m_acc[i] + lat_of(i) + 1) begin
            m_pend[i] <= 1'b0;
          end
        end else if (req_s[i]) begin
          m_pend[i] <= 1'b1;
          m_acc[i]  <= cyc;
          m_we[i]   <= rw_s[i];
          m_addr[i] <= addr_s[i];
          m_wd[i]   <= din_s[i];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready_u%0d", i), rdy_s[i], !m_pend[i]);
        chk($sformatf("ack_u%0d", i), ack_s[i], m_ack[i]);
        chk($sformatf("data_out_u%0d", i), dout_s[i], m_dout[i]);
      end
    end
  end

  task automatic wait_ready(input int i);
    int g;
    g = 0;
    while (rdy_s[i] !== 1'b1 && g < 50) begin
      @(negedge clock);
      g++;
    end
    chk("ready_timeout", (g < 50), 1'b1);
  endtask

  // One full transaction; inputs are scrambled right after acceptance.
  task automatic txn(input int i, input logic rw, input logic [4:0] a, input logic [7:0] d,
                     output logic [7:0] dout, output int acc);
    int n;
    wait_ready(i);
    req_s[i] = 1'b1; rw_s[i] = rw; addr_s[i] = a; din_s[i] = d;
    @(posedge clock); #1;
    acc = cyc;
    req_s[i] = 1'b0; rw_s[i] = ~rw; addr_s[i] = a ^ 5'b00011; din_s[i] = d ^ 8'h04;
    n = 0;
    do begin
      chk("busy_ready", rdy_s[i], 1'b0);
      @(posedge clock); #1;
      n++;
    end while (ack_s[i] !== 1'b1 && n < 30);
    chk("ack_latency", n, lat_of(i));
    chk("ack_ready", rdy_s[i], 1'b0);
    dout = dout_s[i];
    @(posedge clock); #1;
    chk("ack_pulse", ack_s[i], 1'b0);
    chk("ready_back", rdy_s[i], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dout;
    int acc, prev, ackcnt, n;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; rw_s[i] = 1'b0; addr_s[i] = '0; din_s[i] = '0;
    end
    #3 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    chk("reset_ready", rdy_s[0], 1'b1);
    chk("reset_ack", ack_s[0], 1'b0);
    chk("reset_data", dout_s[0], 8'h00);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Read after reset
    txn(0, 1'b0, 5'b10111, 8'h00, dout, acc);
    chk("t1_read_data", dout, 8'h00);

    // Writeback then fill
    txn(0, 1'b1, 5'b01110, 8'h05, dout, acc);
    chk("t2_write_dout", dout, 8'h00);
    txn(0, 1'b0, 5'b01110, 8'h00, dout, acc);
    chk("t2_read_data", dout, 8'h05);

    // Perturbed inputs: txn drives 00010/07 right after accepting 00001/03
    txn(0, 1'b1, 5'b00001, 8'h03, dout, acc);
    txn(0, 1'b0, 5'b00001, 8'h00, dout, acc);
    chk("t3_read_captured", dout, 8'h03);
    txn(0, 1'b0, 5'b00010, 8'h00, dout, acc);
    chk("t3_read_other", dout, 8'h00);

    // Request held high through the busy window
    wait_ready(0);
    req_s[0] = 1'b1; rw_s[0] = 1'b0; addr_s[0] = 5'b01110; din_s[0] = 8'h00;
    @(posedge clock); #1;
    ackcnt = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      if (ack_s[0] === 1'b1) ackcnt++;
    end
    chk("t4_single_ack", ackcnt, 1);
    chk("t4_reaccept", rdy_s[0], 1'b0);
    req_s[0] = 1'b0;
    n = 0;
    while (ack_s[0] !== 1'b1 && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t4_second_latency", n, LAT0);
    chk("t4_second_data", dout_s[0], 8'h05);
    @(posedge clock); #1;

    // Reset during the WAIT of a write
    wait_ready(0);
    req_s[0] = 1'b1; rw_s[0] = 1'b1; addr_s[0] = 5'b11111; din_s[0] = 8'h06;
    @(posedge clock); #1;
    req_s[0] = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ready", rdy_s[0], 1'b1);
    chk("t5_rst_ack", ack_s[0], 1'b0);
    @(posedge clock); #1;
    chk("t5_rst_hold_ack", ack_s[0], 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    txn(0, 1'b0, 5'b11111, 8'h00, dout, acc);
    chk("t5_aborted_write", dout, 8'h00);

    // LATENCY=1 sweep
    prev = 0;
    for (int a = 0; a < 32; a++) begin
      txn(1, 1'b1, 5'(a), 8'(a), dout, acc);
      if (a > 0) chk("t6_period", acc - prev, 3);
      prev = acc;
    end
    for (int a = 0; a < 32; a++) begin
      txn(1, 1'b0, 5'(a), 8'h00, dout, acc);
      chk($sformatf("t6_read_%0d", a), dout, 8'(a));
    end

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
